sb_rr_split_arbiter: RTL and testbench

- Round-robin system-bus arbiter for NUM_MASTERS masters. Adds split masking, locked-transfer hold, burst-safe handover and a parked default master.
- Sits between the master request lines and the shared system-bus mux/decoder. Drives the one-hot grant vector and the owner index that the address/data mux consumes.

---
 rtl/sb_pkg.sv | 24 ++
 rtl/sb_rr_pick.sv | 36 +++
 rtl/sb_rr_split_arbiter.sv | 148 ++++++++++++++
 tb/tb_sb_rr_split_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/sb_pkg.sv
// Shared definitions for the system-bus arbiter family.
// Contents:
//   - transfer-type encodings SB_TRANS_*
//   - slave response encodings SB_RESP_*
//   - arbiter FSM state type sb_state_e
package sb_pkg;

  localparam logic [1:0] SB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] SB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] SB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] SB_TRANS_SEQ    = 2'b11;

  localparam logic [1:0] SB_RESP_OKAY  = 2'b00;
  localparam logic [1:0] SB_RESP_ERROR = 2'b01;
  localparam logic [1:0] SB_RESP_RETRY = 2'b10;
  localparam logic [1:0] SB_RESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    StPark = 2'b00,
    StOwn  = 2'b01,
    StLock = 2'b10
  } sb_state_e;

endpackage

// File: rtl/sb_rr_pick.sv
// Combinational rotating-priority picker.
// Ports:
//   i_req   - request vector
//   i_last  - index of the last winner; the search starts at i_last+1 and wraps
//   o_grant - one-hot winner (all-zero when no request)
//   o_idx   - winner index (0 when no request)
//   o_valid - at least one request present
module sb_rr_pick #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_last,
  output logic [N-1:0] o_grant,
  output logic [W-1:0] o_idx,
  output logic         o_valid
);

  int unsigned w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_j = (32'(i_last) + k) % N;
      if (!o_valid && i_req[w_j]) begin
        o_valid      = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = W'(w_j);
      end
    end
  end

endmodule

// File: rtl/sb_rr_split_arbiter.sv
// Round-robin system-bus arbiter with split masking, locked-transfer hold,
// burst-safe handover and a parked default master.
// Optional feature macro: SB_ARB_TENURE_LIMIT_EN (per-tenure ready-cycle limit).
// Ports:
//   sb_clk, sb_reset         - clock, asynchronous active-high reset
//   sb_busreq, sb_lock       - per-master request / locked request
//   sb_split_ar              - per-master split-release pulse
//   sb_trans_ar, sb_resp_ar  - current transfer type and slave response
//   sb_ready_ar              - transfer complete
//   sb_grant, sb_masters     - registered one-hot grant and owner index
//   sb_mastlock              - registered: current tenure is locked
//   sb_split_mask            - masters blocked by SPLIT
module sb_rr_split_arbiter
  import sb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned MW             = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1,
  parameter int unsigned DEFAULT_MASTER = 0,
  parameter int unsigned MAX_TENURE     = 16
) (
  input  logic                   sb_clk,
  input  logic                   sb_reset,
  input  logic [NUM_MASTERS-1:0] sb_busreq,
  input  logic [NUM_MASTERS-1:0] sb_lock,
  input  logic [NUM_MASTERS-1:0] sb_split_ar,
  input  logic [1:0]             sb_trans_ar,
  input  logic [1:0]             sb_resp_ar,
  input  logic                   sb_ready_ar,
  output logic [NUM_MASTERS-1:0] sb_grant,
  output logic [MW-1:0]          sb_masters,
  output logic                   sb_mastlock,
  output logic [NUM_MASTERS-1:0] sb_split_mask
);

  localparam logic [NUM_MASTERS-1:0] LP_DEF_OH =
    {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
  localparam logic [MW-1:0] LP_DEF_IDX = MW'(DEFAULT_MASTER);

  sb_state_e              r_state, w_state_d;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_d;
  logic [MW-1:0]          r_masters, w_masters_d;
  logic                   r_mastlock;
  logic [NUM_MASTERS-1:0] r_mask, w_mask_d;
  logic [MW-1:0]          r_ptr, w_ptr_d;

  logic                   w_ap, w_owned, w_split, w_retry, w_hold_lock;
  logic [NUM_MASTERS-1:0] w_elig, w_pick_req, w_pick_grant;
  logic [MW-1:0]          w_pick_idx;
  logic                   w_pick_valid;

  assign w_ap    = sb_ready_ar && (sb_trans_ar != SB_TRANS_SEQ) && (sb_trans_ar != SB_TRANS_BUSY);
  assign w_owned = (r_state != StPark);
  assign w_split = sb_ready_ar && (sb_resp_ar == SB_RESP_SPLIT) && w_owned;
  assign w_retry = sb_ready_ar && (sb_resp_ar == SB_RESP_RETRY) && w_owned;

  // Release is applied before a new SPLIT so a same-edge pair leaves the bit set.
  always_comb begin
    w_mask_d = r_mask & ~sb_split_ar;
    if (w_split) w_mask_d[r_masters] = 1'b1;
  end

  // Arbitrate against the post-update mask so a splitting owner cannot win back.
  assign w_elig      = sb_busreq & ~w_mask_d;
  assign w_hold_lock = (r_state == StLock) && sb_lock[r_masters] && !w_split;

`ifdef SB_ARB_TENURE_LIMIT_EN
  logic [7:0] r_tenure;
  logic       w_expired;

  assign w_expired  = (r_state == StOwn) && (r_tenure >= 8'(MAX_TENURE)) &&
                      ((w_elig & ~r_grant) != '0);
  // Expired owner is removed from the search so another requester must win.
  assign w_pick_req = w_expired ? (w_elig & ~r_grant) : w_elig;

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      r_tenure <= 8'd0;
    end else if (w_grant_d != r_grant) begin
      r_tenure <= 8'd0;
    end else if ((r_state == StOwn) && sb_ready_ar && (r_tenure != 8'hFF)) begin
      r_tenure <= r_tenure + 8'd1;
    end
  end
`else
  assign w_pick_req = w_elig;
`endif

  sb_rr_pick #(
    .N(NUM_MASTERS),
    .W(MW)
  ) u_pick (
    .i_req  (w_pick_req),
    .i_last (r_ptr),
    .o_grant(w_pick_grant),
    .o_idx  (w_pick_idx),
    .o_valid(w_pick_valid)
  );

  always_comb begin
    w_state_d   = r_state;
    w_grant_d   = r_grant;
    w_masters_d = r_masters;
    w_ptr_d     = r_ptr;
    if (w_ap || w_split || w_retry) begin
      if (w_hold_lock) begin
        w_state_d = StLock;
      end else if (w_pick_valid) begin
        w_grant_d   = w_pick_grant;
        w_masters_d = w_pick_idx;
        w_ptr_d     = w_pick_idx;
        w_state_d   = sb_lock[w_pick_idx] ? StLock : StOwn;
      end else begin
        w_state_d = StPark;
        if (w_mask_d[DEFAULT_MASTER]) begin
          // Masked default: drive no grant, keep the last owner index.
          w_grant_d = '0;
        end else begin
          w_grant_d   = LP_DEF_OH;
          w_masters_d = LP_DEF_IDX;
        end
      end
    end
  end

  always_ff @(posedge sb_clk or posedge sb_reset) begin
    if (sb_reset) begin
      r_state    <= StPark;
      r_grant    <= LP_DEF_OH;
      r_masters  <= LP_DEF_IDX;
      r_mastlock <= 1'b0;
      r_mask     <= '0;
      r_ptr      <= LP_DEF_IDX;
    end else begin
      r_state    <= w_state_d;
      r_grant    <= w_grant_d;
      r_masters  <= w_masters_d;
      r_mastlock <= (w_state_d == StLock);
      r_mask     <= w_mask_d;
      r_ptr      <= w_ptr_d;
    end
  end

  assign sb_grant      = r_grant;
  assign sb_masters    = r_masters;
  assign sb_mastlock   = r_mastlock;
  assign sb_split_mask = r_mask;

endmodule

// File: tb/tb_sb_rr_split_arbiter.sv
module tb_sb_rr_split_arbiter;
  import sb_pkg::*;

  localparam int unsigned N  = 2;
  localparam int unsigned MW = 1;

  logic          sb_clk = 1'b0;
  logic          sb_reset;
  logic [N-1:0]  sb_busreq, sb_lock, sb_split_ar;
  logic [1:0]    sb_trans_ar, sb_resp_ar;
  logic          sb_ready_ar;
  logic [N-1:0]  sb_grant, sb_split_mask;
  logic [MW-1:0] sb_masters;
  logic          sb_mastlock;

  always #5 sb_clk = ~sb_clk;

  sb_rr_split_arbiter #(
    .NUM_MASTERS(N),
    .MW(MW),
    .DEFAULT_MASTER(0),
    .MAX_TENURE(16)
  ) dut (
    .sb_clk       (sb_clk),
    .sb_reset     (sb_reset),
    .sb_busreq    (sb_busreq),
    .sb_lock      (sb_lock),
    .sb_split_ar  (sb_split_ar),
    .sb_trans_ar  (sb_trans_ar),
    .sb_resp_ar   (sb_resp_ar),
    .sb_ready_ar  (sb_ready_ar),
    .sb_grant     (sb_grant),
    .sb_masters   (sb_masters),
    .sb_mastlock  (sb_mastlock),
    .sb_split_mask(sb_split_mask)
  );

  typedef struct packed {
    logic [N-1:0]  br;
    logic [N-1:0]  lk;
    logic [N-1:0]  sar;
    logic [1:0]    tr;
    logic [1:0]    rs;
    logic          rdy;
    logic [N-1:0]  eg;
    logic [MW-1:0] em;
    logic          el;
    logic [N-1:0]  emask;
  } vec_t;

  typedef logic [N+MW+1+N-1:0] obs_t;

  vec_t tbl[$];
  obs_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic obs_t observe();
    return {sb_grant, sb_masters, sb_mastlock, sb_split_mask};
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%b masters=%0d mastlock=%b mask=%b, want grant=%b masters=%0d mastlock=%b mask=%b",
                  name, act[5:4], act[3], act[2], act[1:0], exp[5:4], exp[3], exp[2], exp[1:0]);
  endtask

  task automatic add(input logic [1:0] br, lk, sar, tr, rs, input logic rdy,
                     input logic [1:0] eg, input logic em, el, input logic [1:0] emask);
    vec_t v;
    v = '{br: br, lk: lk, sar: sar, tr: tr, rs: rs, rdy: rdy, eg: eg, em: em, el: el, emask: emask};
    tbl.push_back(v);
  endtask

  task automatic drive_idle();
    sb_busreq = '0; sb_lock = '0; sb_split_ar = '0;
    sb_trans_ar = SB_TRANS_IDLE; sb_resp_ar = SB_RESP_OKAY; sb_ready_ar = 1'b0;
  endtask

  // Drive one cycle of stimulus, queue its expected post-edge outputs, then compare.
  task automatic step(input string name, input vec_t v);
    obs_t exp;
    @(negedge sb_clk);
    sb_busreq = v.br; sb_lock = v.lk; sb_split_ar = v.sar;
    sb_trans_ar = v.tr; sb_resp_ar = v.rs; sb_ready_ar = v.rdy;
    sb_q.push_back({v.eg, v.em, v.el, v.emask});
    @(posedge sb_clk);
    #1;
    exp = sb_q.pop_front();
    check(name, observe(), exp);
  endtask

  localparam logic [1:0] I = SB_TRANS_IDLE, NS = SB_TRANS_NONSEQ, S = SB_TRANS_SEQ;
  localparam logic [1:0] OK = SB_RESP_OKAY, ER = SB_RESP_ERROR, RT = SB_RESP_RETRY,
                         SP = SB_RESP_SPLIT;

  initial begin
    vec_t v;
    // br    lk    sar   tr  rs  rdy  eg    em lk mask
    // Round robin from park, pointer starts after M0.
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    // Burst: NONSEQ waiting, SEQ x3 hold grant, handover after burst.
    add(2'b11, 2'b00, 2'b00, NS, OK, 0, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, S,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, S,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, S,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b00);
    // Lock: M0 enters LOCK, holds across 6 APs, released when lock drops.
    add(2'b01, 2'b01, 2'b00, I,  OK, 1, 2'b01, 0, 1, 2'b00);
    for (int k = 0; k < 6; k++) add(2'b11, 2'b01, 2'b00, I, OK, 1, 2'b01, 0, 1, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b00);
    // Split mid-burst, M0 ignored, release pulse, M0 wins next AP.
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, S,  SP, 1, 2'b10, 1, 0, 2'b01);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b01);
    add(2'b11, 2'b00, 2'b01, S,  OK, 1, 2'b10, 1, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    // RETRY mid-burst forces handover without masking.
    add(2'b11, 2'b00, 2'b00, S,  RT, 1, 2'b10, 1, 0, 2'b00);
    // Split of the only requester, which is the default: park with no grant.
    add(2'b01, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b01, 2'b00, 2'b00, S,  SP, 1, 2'b00, 0, 0, 2'b01);
    add(2'b00, 2'b00, 2'b00, I,  OK, 1, 2'b00, 0, 0, 2'b01);
    add(2'b00, 2'b00, 2'b01, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    // Same-edge release plus SPLIT on the owner leaves the mask set.
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b10, 1, 0, 2'b00);
    add(2'b11, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    add(2'b11, 2'b00, 2'b01, S,  SP, 1, 2'b10, 1, 0, 2'b01);
    // ERROR response has no arbitration effect; release clears M0.
    add(2'b11, 2'b00, 2'b01, S,  ER, 1, 2'b10, 1, 0, 2'b00);
    // Owner drops request: grant held until an AP.
    add(2'b01, 2'b00, 2'b00, S,  OK, 1, 2'b10, 1, 0, 2'b00);
    add(2'b01, 2'b00, 2'b00, I,  OK, 0, 2'b10, 1, 0, 2'b00);
    add(2'b01, 2'b00, 2'b00, I,  OK, 1, 2'b01, 0, 0, 2'b00);
    // Set up a mask ahead of the mid-transfer reset.
    add(2'b11, 2'b00, 2'b00, S,  SP, 1, 2'b10, 1, 0, 2'b01);

    drive_idle();
    sb_reset = 1'b1;
    repeat (3) @(posedge sb_clk);
    @(negedge sb_clk);
    sb_reset = 1'b0;
    #1;
    check("reset_state", observe(), {2'b01, 1'b0, 1'b0, 2'b00});

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i]);

    // Mid-transfer asynchronous reset: outputs return without a clock edge.
    @(negedge sb_clk);
    sb_busreq = 2'b11; sb_trans_ar = S; sb_ready_ar = 1'b0;
    #2;
    sb_reset = 1'b1;
    #1;
    check("async_reset", observe(), {2'b01, 1'b0, 1'b0, 2'b00});
    @(negedge sb_clk);
    drive_idle();
    sb_reset = 1'b0;
    // Pointer back at default: M1 wins first, mask was lost.
    v = '{br: 2'b11, lk: 2'b00, sar: 2'b00, tr: I, rs: OK, rdy: 1'b1,
          eg: 2'b10, em: 1'b1, el: 1'b0, emask: 2'b00};
    step("post_reset_rr", v);
    v = '{br: 2'b00, lk: 2'b00, sar: 2'b00, tr: I, rs: OK, rdy: 1'b1,
          eg: 2'b01, em: 1'b0, el: 1'b0, emask: 2'b00};
    step("park_none", v);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
